// File: rtl/pbl_apb_pkg.sv
// rtl/pbl_apb_pkg.sv - shared constants, FSM states and decode helper for the FIR APB slave
package pbl_apb_pkg;

  localparam logic [31:0] PBL_ID_VAL = 32'h5042_4C01;
  localparam int unsigned PBL_N_WSP  = 32;

  localparam int W_WSP    = 6;
  localparam int W_PROBEK = 14;
  localparam int W_RAZY   = 15;
  localparam int W_COEF   = 16;

  localparam logic [W_WSP-1:0] WSP_MAX = 6'd32;

  localparam logic [11:0] OFF_CTRL       = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h004;
  localparam logic [11:0] OFF_ILE_WSP    = 12'h008;
  localparam logic [11:0] OFF_ILE_PROBEK = 12'h00C;
  localparam logic [11:0] OFF_ILE_RAZY   = 12'h010;
  localparam logic [11:0] OFF_ID         = 12'h014;
  localparam logic [11:0] OFF_COEF       = 12'h100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } apb_st_t;

  // Coefficient window is 0x100..0x17C: 32 words sharing address bits [11:7].
  function automatic logic is_coef(input logic [11:0] addr);
    return addr[11:7] == OFF_COEF[11:7];
  endfunction

endpackage

// File: rtl/pbl_coef_ram.sv
// rtl/pbl_coef_ram.sv - single-port coefficient bank with synchronous read, no reset
module pbl_coef_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write-first is not needed: a read in the same cycle as a write returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pbl_apb_regs.sv
// rtl/pbl_apb_regs.sv - APB register slave holding FIR run configuration and coefficient bank
module pbl_apb_regs
  import pbl_apb_pkg::*;
#(
  parameter int unsigned N_WSP  = PBL_N_WSP,
  parameter logic [31:0] ID_VAL = PBL_ID_VAL
) (
  input  logic                     a_clk,
  input  logic                     a_rst,
  input  logic [11:0]              p_paddr,
  input  logic                     p_psel,
  input  logic                     p_penable,
  input  logic                     p_pwrite,
  input  logic [31:0]              p_pwdata,
  output logic [31:0]              p_prdata,
  output logic                     p_pready,
  output logic                     p_pslverr,
  output logic [W_WSP-1:0]         f_ile_wsp,
  output logic [W_PROBEK-1:0]      f_ile_probek,
  output logic [W_RAZY-1:0]        f_ile_razy,
  output logic                     f_start,
  input  logic [$clog2(N_WSP)-1:0] f_adress_fir,
  output logic [W_COEF-1:0]        f_wsp_data,
  input  logic                     f_fsm_mux_cdc,
  input  logic                     f_pracuje,
  input  logic                     f_done
);

  localparam int AW = $clog2(N_WSP);

  apb_st_t              st_q, st_d;
  logic [W_WSP-1:0]     ile_wsp_q, ile_wsp_d;
  logic [W_PROBEK-1:0]  ile_probek_q, ile_probek_d;
  logic [W_RAZY-1:0]    ile_razy_q, ile_razy_d;
  logic                 done_q, done_d;
  logic                 start_q, start_d;
  logic                 fir_sel_q, fir_sel_d;
  logic [W_COEF-1:0]    wsp_hold_q, wsp_hold_d;
  logic [W_COEF-1:0]    ram_rdata;
  logic [AW-1:0]        ram_addr;
  logic [11:0]          addr_w;
  logic [31:0]          reg_rdata;
  logic                 in_coef, acc_phase, acc_err, wr_fire, coef_rd_fire, ram_we;
  logic                 unused_addr_lsb;

  assign addr_w          = {p_paddr[11:2], 2'b00};
  assign unused_addr_lsb = ^p_paddr[1:0];
  assign in_coef         = is_coef(addr_w);
  assign acc_phase       = (st_q == ST_ACCESS) && p_psel && p_penable;

  // Address decode: access legality and register read value for the current transfer.
  always_comb begin
    acc_err   = 1'b0;
    reg_rdata = '0;
    if (in_coef) begin
      acc_err = f_fsm_mux_cdc || (p_pwrite && f_pracuje);
    end else begin
      case (addr_w)
        OFF_CTRL:       acc_err = p_pwrite && (f_pracuje || (ile_wsp_q == '0));
        OFF_STATUS:     reg_rdata = {30'd0, done_q, f_pracuje};
        OFF_ILE_WSP: begin
          acc_err   = p_pwrite && (f_pracuje || (p_pwdata > 32'(WSP_MAX)));
          reg_rdata = {{(32-W_WSP){1'b0}}, ile_wsp_q};
        end
        OFF_ILE_PROBEK: begin
          acc_err   = p_pwrite && f_pracuje;
          reg_rdata = {{(32-W_PROBEK){1'b0}}, ile_probek_q};
        end
        OFF_ILE_RAZY: begin
          acc_err   = p_pwrite && f_pracuje;
          reg_rdata = {{(32-W_RAZY){1'b0}}, ile_razy_q};
        end
        OFF_ID: begin
          acc_err   = p_pwrite;
          reg_rdata = ID_VAL;
        end
        default:        acc_err = 1'b1;
      endcase
    end
  end

  assign wr_fire      = acc_phase && p_pwrite && !acc_err;
  assign coef_rd_fire = acc_phase && !p_pwrite && !acc_err && in_coef;

  // Transfer FSM: only a legal coefficient read needs the extra WAIT cycle for the RAM.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:   if (p_psel && !p_penable) st_d = ST_ACCESS;
      ST_ACCESS: begin
        if (!p_psel) begin
          st_d = ST_IDLE;
        end else if (p_penable) begin
          st_d = coef_rd_fire ? ST_WAIT : ST_IDLE;
        end
      end
      default:   st_d = ST_IDLE;
    endcase
  end

  // Response: completion in ACCESS for everything but coefficient reads, which finish in WAIT.
  always_comb begin
    p_pready  = 1'b0;
    p_pslverr = 1'b0;
    p_prdata  = '0;
    if (acc_phase && !coef_rd_fire) begin
      p_pready  = 1'b1;
      p_pslverr = acc_err;
      if (!p_pwrite && !acc_err) p_prdata = reg_rdata;
    end else if ((st_q == ST_WAIT) && p_psel) begin
      p_pready = 1'b1;
      p_prdata = {{(32-W_COEF){ram_rdata[W_COEF-1]}}, ram_rdata};
    end
  end

  // Register next-state: accepted writes, sticky DONE where a new done pulse beats the clear.
  always_comb begin
    ile_wsp_d    = ile_wsp_q;
    ile_probek_d = ile_probek_q;
    ile_razy_d   = ile_razy_q;
    start_d      = 1'b0;
    done_d       = done_q;
    if (wr_fire) begin
      case (addr_w)
        OFF_CTRL:       start_d      = p_pwdata[0];
        OFF_STATUS:     done_d       = done_q && !p_pwdata[1];
        OFF_ILE_WSP:    ile_wsp_d    = p_pwdata[W_WSP-1:0];
        OFF_ILE_PROBEK: ile_probek_d = p_pwdata[W_PROBEK-1:0];
        OFF_ILE_RAZY:   ile_razy_d   = p_pwdata[W_RAZY-1:0];
        default:        ;
      endcase
    end
    if (f_done) done_d = 1'b1;
    fir_sel_d  = f_fsm_mux_cdc;
    wsp_hold_d = fir_sel_q ? ram_rdata : wsp_hold_q;
  end

  // State and register flops.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      st_q         <= ST_IDLE;
      ile_wsp_q    <= '0;
      ile_probek_q <= '0;
      ile_razy_q   <= '0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      fir_sel_q    <= 1'b0;
      wsp_hold_q   <= '0;
    end else begin
      st_q         <= st_d;
      ile_wsp_q    <= ile_wsp_d;
      ile_probek_q <= ile_probek_d;
      ile_razy_q   <= ile_razy_d;
      start_q      <= start_d;
      done_q       <= done_d;
      fir_sel_q    <= fir_sel_d;
      wsp_hold_q   <= wsp_hold_d;
    end
  end

  // Bank port owner: FIR when it holds the mux, otherwise APB (APB writes are refused then).
  assign ram_addr = f_fsm_mux_cdc ? f_adress_fir : p_paddr[2 +: AW];
  assign ram_we   = wr_fire && in_coef;

  pbl_coef_ram #(
    .DEPTH (N_WSP),
    .W     (W_COEF)
  ) u_coef_ram (
    .clk   (a_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (p_pwdata[W_COEF-1:0]),
    .rdata (ram_rdata)
  );

  assign f_ile_wsp    = ile_wsp_q;
  assign f_ile_probek = ile_probek_q;
  assign f_ile_razy   = ile_razy_q;
  assign f_start      = start_q;
  assign f_wsp_data   = fir_sel_q ? ram_rdata : wsp_hold_q;

endmodule

// File: tb/tb_pbl_apb_regs.sv
// tb/tb_pbl_apb_regs.sv - randomized self-checking bench for pbl_apb_regs
module tb_pbl_apb_regs;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [11:0] p_paddr = '0;
  logic        p_psel = 1'b0, p_penable = 1'b0, p_pwrite = 1'b0;
  logic [31:0] p_pwdata = '0;
  logic [31:0] p_prdata;
  logic        p_pready, p_pslverr;
  logic [5:0]  f_ile_wsp;
  logic [13:0] f_ile_probek;
  logic [14:0] f_ile_razy;
  logic        f_start;
  logic [4:0]  f_adress_fir = '0;
  logic [15:0] f_wsp_data;
  logic        f_fsm_mux_cdc = 1'b0, f_pracuje = 1'b0, f_done = 1'b0;

  pbl_apb_regs #(.N_WSP(32), .ID_VAL(32'h5042_4C01)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .p_paddr(p_paddr), .p_psel(p_psel), .p_penable(p_penable), .p_pwrite(p_pwrite),
    .p_pwdata(p_pwdata), .p_prdata(p_prdata), .p_pready(p_pready), .p_pslverr(p_pslverr),
    .f_ile_wsp(f_ile_wsp), .f_ile_probek(f_ile_probek), .f_ile_razy(f_ile_razy),
    .f_start(f_start), .f_adress_fir(f_adress_fir), .f_wsp_data(f_wsp_data),
    .f_fsm_mux_cdc(f_fsm_mux_cdc), .f_pracuje(f_pracuje), .f_done(f_done)
  );

  always #5 a_clk = ~a_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_coef [32];
  int          m_wsp = 0, m_probek = 0, m_razy = 0;
  bit          m_done = 0, exp_start = 0;
  logic [15:0] exp_wsp = '0;
  bit          mon_en = 0, rand_en = 0, dwa = 0;
  logic [11:0] unm [6] = '{12'h018, 12'h080, 12'h0FC, 12'h180, 12'h200, 12'hFFC};
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wsp = 0; m_probek = 0; m_razy = 0; m_done = 0; exp_start = 0; exp_wsp = '0;
  endtask

  // Expected response of one transfer from the register map rules.
  task automatic model_resp(input bit wr, input logic [11:0] a_in, input logic [31:0] wd,
                            output bit e_err, output bit e_wait, output logic [31:0] e_rd);
    int      off;
    shortint s;
    off = int'(a_in) & ~3;
    e_err = 0; e_wait = 0; e_rd = '0;
    if (off >= 'h100 && off <= 'h17C) begin
      if (f_fsm_mux_cdc || (wr && f_pracuje)) e_err = 1;
      else if (!wr) begin
        s = shortint'(m_coef[(off - 'h100) / 4]);
        e_wait = 1;
        e_rd = 32'(int'(s));
      end
    end else if (off == 'h0) begin
      if (wr) e_err = f_pracuje || (m_wsp == 0);
    end else if (off == 'h4) e_rd = {30'd0, m_done, f_pracuje};
    else if (off == 'h8) begin
      if (wr) e_err = f_pracuje || (wd > 32);
      e_rd = 32'(m_wsp);
    end else if (off == 'hC) begin
      if (wr) e_err = f_pracuje;
      e_rd = 32'(m_probek);
    end else if (off == 'h10) begin
      if (wr) e_err = f_pracuje;
      e_rd = 32'(m_razy);
    end else if (off == 'h14) begin
      if (wr) e_err = 1;
      e_rd = 32'h5042_4C01;
    end else e_err = 1;
  endtask

  task automatic model_write(input logic [11:0] a_in, input logic [31:0] wd);
    int off;
    off = int'(a_in) & ~3;
    if (off >= 'h100 && off <= 'h17C) m_coef[(off - 'h100) / 4] = wd[15:0];
    else if (off == 'h0) begin if (wd[0]) exp_start = 1; end
    else if (off == 'h4) begin if (wd[1]) m_done = f_done; end
    else if (off == 'h8) m_wsp = int'(wd);
    else if (off == 'hC) m_probek = int'(wd % 16384);
    else if (off == 'h10) m_razy = int'(wd % 32768);
  endtask

  task automatic apb(input bit wr, input logic [11:0] a_in, input logic [31:0] wd,
                     output logic [31:0] rdv, output logic erv);
    bit          e_err, e_wait;
    logic [31:0] e_rd;
    @(posedge a_clk); #1;
    p_psel = 1; p_penable = 0; p_pwrite = wr; p_paddr = a_in; p_pwdata = wd;
    @(posedge a_clk); #1;
    p_penable = 1;
    if (dwa) f_done = 1;
    model_resp(wr, a_in, wd, e_err, e_wait, e_rd);
    @(negedge a_clk);
    if (e_wait) begin
      chk("pready_wait_state", 32'(p_pready), 32'd0);
      @(negedge a_clk);
    end
    chk("pready", 32'(p_pready), 32'd1);
    chk("pslverr", 32'(p_pslverr), 32'(e_err));
    if (!wr) chk("prdata", p_prdata, e_rd);
    rdv = p_prdata; erv = p_pslverr;
    @(posedge a_clk);
    if (wr && !e_err) model_write(a_in, wd);
    #1;
    p_psel = 0; p_penable = 0;
    if (dwa) f_done = 0;
  endtask

  // Model side effects that happen on every edge regardless of APB traffic.
  always @(posedge a_clk) begin
    if (mon_en) begin
      if (f_done) m_done = 1;
      if (f_fsm_mux_cdc) exp_wsp = m_coef[f_adress_fir];
    end
  end

  // Per-cycle output compare against the model.
  always @(negedge a_clk) begin
    if (mon_en) begin
      chk("f_ile_wsp", 32'(f_ile_wsp), 32'(m_wsp));
      chk("f_ile_probek", 32'(f_ile_probek), 32'(m_probek));
      chk("f_ile_razy", 32'(f_ile_razy), 32'(m_razy));
      chk("f_start", 32'(f_start), 32'(exp_start));
      exp_start = 0;
      chk("f_wsp_data", 32'(f_wsp_data), 32'(exp_wsp));
    end
  end

  // Random FIR-side activity during the randomized phase.
  always @(posedge a_clk) begin
    if (rand_en) begin
      #1;
      f_adress_fir = 5'($urandom);
      f_done = ($urandom_range(0, 7) == 0);
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    bit          wr;

    repeat (3) @(posedge a_clk);
    @(negedge a_clk);
    chk("rst_pready", 32'(p_pready), 32'd0);
    chk("rst_start", 32'(f_start), 32'd0);
    chk("rst_ile_wsp", 32'(f_ile_wsp), 32'd0);
    chk("rst_wsp_data", 32'(f_wsp_data), 32'd0);
    @(posedge a_clk); #1;
    a_rst = 0;
    model_reset();
    mon_en = 1;

    apb(0, 12'h014, 0, rd, er);
    chk("id_value", rd, 32'h5042_4C01);
    chk("id_err", 32'(er), 32'd0);

    for (int i = 0; i < 32; i++) apb(1, 12'(12'h100 + 4 * i), $urandom, rd, er);
    apb(1, 12'h114, 32'h0000_FF38, rd, er);
    apb(0, 12'h114, 0, rd, er);
    chk("coef5_read", rd, 32'hFFFF_FF38);

    @(posedge a_clk); #1;
    f_fsm_mux_cdc = 1; f_adress_fir = 5;
    @(posedge a_clk); #1;
    chk("fir_coef5", 32'(f_wsp_data), 32'h0000_FF38);
    f_fsm_mux_cdc = 0;

    apb(1, 12'h008, 16, rd, er);
    apb(1, 12'h00C, 1000, rd, er);
    apb(1, 12'h010, 3, rd, er);
    apb(1, 12'h000, 1, rd, er);
    #1;
    chk("start_high", 32'(f_start), 32'd1);
    chk("out_wsp", 32'(f_ile_wsp), 32'd16);
    chk("out_probek", 32'(f_ile_probek), 32'd1000);
    chk("out_razy", 32'(f_ile_razy), 32'd3);
    @(posedge a_clk); #1;
    chk("start_one_cycle", 32'(f_start), 32'd0);

    apb(1, 12'h008, 0, rd, er);
    apb(1, 12'h000, 1, rd, er);
    chk("ctrl_wsp0_err", 32'(er), 32'd1);
    apb(1, 12'h008, 16, rd, er);

    f_pracuje = 1;
    apb(1, 12'h00C, 5, rd, er);
    chk("busy_write_err", 32'(er), 32'd1);
    chk("busy_probek_kept", 32'(f_ile_probek), 32'd1000);
    f_pracuje = 0;
    f_fsm_mux_cdc = 1;
    apb(0, 12'h100, 0, rd, er);
    chk("mux_coef_err", 32'(er), 32'd1);
    chk("mux_coef_zero", rd, 32'd0);
    f_fsm_mux_cdc = 0;

    @(posedge a_clk); #1; f_done = 1;
    @(posedge a_clk); #1; f_done = 0;
    apb(0, 12'h004, 0, rd, er);
    chk("status_done", rd, 32'd2);
    dwa = 1;
    apb(1, 12'h004, 2, rd, er);
    dwa = 0;
    apb(0, 12'h004, 0, rd, er);
    chk("status_set_wins", rd, 32'd2);
    apb(1, 12'h004, 2, rd, er);
    apb(0, 12'h004, 0, rd, er);
    chk("status_cleared", rd, 32'd0);

    apb(1, 12'h008, 33, rd, er);
    chk("wsp33_err", 32'(er), 32'd1);
    chk("wsp33_kept", 32'(f_ile_wsp), 32'd16);

    @(posedge a_clk); #1;
    p_psel = 1; p_penable = 0; p_pwrite = 0; p_paddr = 12'h108;
    @(posedge a_clk); #1; p_penable = 1;
    @(posedge a_clk); #1; p_psel = 0; p_penable = 0;
    @(negedge a_clk);
    chk("abort_pready", 32'(p_pready), 32'd0);
    apb(0, 12'h108, 0, rd, er);

    rand_en = 1;
    for (int n = 0; n < 400; n++) begin
      wr = 1'($urandom);
      wd = $urandom;
      case ($urandom_range(0, 9))
        0: begin a = 12'h000; if ($urandom_range(0, 3) != 0) wd = 1; end
        1: a = 12'h004;
        2: begin a = 12'h008; wd = $urandom_range(0, 40); end
        3: a = 12'h00C;
        4: a = 12'h010;
        5: a = 12'h014;
        8: a = unm[$urandom_range(0, 5)];
        default: a = 12'(12'h100 + 4 * $urandom_range(0, 31));
      endcase
      a = a | 12'($urandom_range(0, 3));
      f_pracuje = ($urandom_range(0, 3) == 0);
      f_fsm_mux_cdc = ($urandom_range(0, 3) == 0);
      apb(wr, a, wd, rd, er);
    end
    rand_en = 0;
    @(posedge a_clk); #2;
    f_done = 0; f_pracuje = 0; f_fsm_mux_cdc = 0;

    apb(1, 12'h008, 7, rd, er);
    apb(1, 12'h010, 9, rd, er);
    @(posedge a_clk); #1;
    p_psel = 1; p_penable = 0; p_pwrite = 0; p_paddr = 12'h10C;
    @(posedge a_clk); #1; p_penable = 1;
    @(posedge a_clk); #1;
    a_rst = 1; mon_en = 0;
    #1;
    chk("rst_wait_pready", 32'(p_pready), 32'd0);
    chk("rst_wait_prdata", p_prdata, 32'd0);
    chk("rst_wait_pslverr", 32'(p_pslverr), 32'd0);
    chk("rst_wait_outs", {f_ile_wsp, f_ile_probek, f_ile_razy, f_start}, 32'd0);
    chk("rst_wait_wsp_data", 32'(f_wsp_data), 32'd0);
    p_psel = 0; p_penable = 0;
    @(posedge a_clk); #1;
    a_rst = 0;
    model_reset();
    mon_en = 1;
    apb(0, 12'h008, 0, rd, er);
    apb(0, 12'h10C, 0, rd, er);

    repeat (2) @(posedge a_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
